// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for pipe_skid_stage: upstream (in_*) and downstream (out_*) sides.
// slave = the stage itself, master = the environment driving it.
interface pipe_skid_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: main + skid register, valid/ready on both sides, FLUSH inserts a bubble.
// Optional macro PIPE_ZERO_BUBBLE_EN zeroes payload registers whenever they stop holding a valid entry.
module pipe_skid_stage #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    FLUSH,
    pipe_skid_stage_if.slave        bus,
    output logic [1:0]              occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    logic in_ready_w;
    logic out_valid_w;
    logic in_fire;
    logic out_fire;

    // Handshake flags come only from registered state, so no combinational path crosses the stage.
    assign in_ready_w  = (state_q != ST_FULL);
    assign out_valid_w = (state_q != ST_EMPTY);
    assign in_fire     = bus.in_valid & in_ready_w;
    assign out_fire    = out_valid_w & bus.out_ready;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = main_q;
    assign occupancy     = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = bus.in_data;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = bus.in_data;
                end else if (in_fire) begin
                    state_d = ST_FULL;
                    skid_d  = bus.in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
`ifdef PIPE_ZERO_BUBBLE_EN
                    main_d  = '0;
`endif
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
`ifdef PIPE_ZERO_BUBBLE_EN
                    skid_d  = '0;
`endif
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush discards everything, including a payload handshaken in this same cycle.
        if (FLUSH) begin
            state_d = ST_EMPTY;
`ifdef PIPE_ZERO_BUBBLE_EN
            main_d  = '0;
            skid_d  = '0;
`else
            main_d  = main_q;
            skid_d  = skid_q;
`endif
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
